// File: rtl/prog_loader_pkg.sv
// Shared loader state encoding, frame sync byte, and core opcodes used when
// building test programs.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    OK,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [31:0] OP_LED   = 32'h2000_0000;
  localparam logic [31:0] OP_SLEEP = 32'h1000_0000;
  localparam logic [31:0] OP_JUMP0 = 32'h3000_0000;

  function automatic logic [31:0] op_led(input logic [3:0] pattern);
    return OP_LED | {28'd0, pattern};
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Inter-byte idle timer: counts up while enabled and flags expiry once it
// reaches TIMEOUT. It holds at TIMEOUT until cleared.
module loader_timer #(
  parameter int unsigned TIMEOUT = 160000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (enable && !expired)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == W'(TIMEOUT));

endmodule

// File: rtl/prog_loader.sv
// Instruction-RAM writer: parses framed byte stream, writes big-endian words
// from address 0, holds the core while loading and flags frame accept/reject.
//
//   state  | meaning
//   IDLE   | discard bytes until SYNC
//   LEN_HI | waiting for length high byte
//   LEN_LO | waiting for length low byte, range-check LEN
//   DATA   | collecting 4 bytes of the current word
//   WRITE  | one-cycle RAM write, rx stalled
//   CSUM   | waiting for checksum byte
//   OK     | one-cycle accept pulse, release core
//   ERR    | one-cycle reject pulse, core stays held
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned TIMEOUT = 160000,
  parameter logic [7:0]  SYNC    = SYNC_BYTE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned MAX_LEN = 2 ** ADDR_W;

  state_t          state, state_nx;
  logic [15:0]     len;
  logic [7:0]      chk;
  logic [ADDR_W:0] wr_cnt;
  logic [31:0]     word;
  logic [1:0]      byte_idx;

  logic            rx_fire;
  logic            expired;
  logic [15:0]     len_in;
  logic [7:0]      chk_in;
  logic [ADDR_W:0] wr_nxt;

  assign rx_ready = (state != WRITE) && (state != OK) && (state != ERR);
  assign rx_fire  = rx_valid && rx_ready;
  assign len_in   = {len[15:8], rx_data};
  assign chk_in   = chk + rx_data;
  assign wr_nxt   = wr_cnt + 1'b1;

  assign ram_we     = (state == WRITE);
  assign ram_addr   = wr_cnt[ADDR_W-1:0];
  assign ram_wdata  = word;
  assign load_done  = (state == OK);
  assign load_error = (state == ERR);

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (rx_fire || (state == IDLE)),
    .enable  (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (rx_fire && rx_data == SYNC) state_nx = LEN_HI;
      LEN_HI: if (rx_fire) state_nx = LEN_LO;
              else if (expired) state_nx = ERR;
      LEN_LO: if (rx_fire) begin
                if (32'(len_in) > MAX_LEN) state_nx = ERR;
                else if (len_in == 16'd0)  state_nx = CSUM;
                else                       state_nx = DATA;
              end else if (expired) state_nx = ERR;
      DATA:   if (rx_fire) begin
                if (byte_idx == 2'd3) state_nx = WRITE;
              end else if (expired) state_nx = ERR;
      WRITE:  state_nx = (16'(wr_nxt) == len) ? CSUM : DATA;
      CSUM:   if (rx_fire) state_nx = (chk_in == 8'd0) ? OK : ERR;
              else if (expired) state_nx = ERR;
      OK:     state_nx = IDLE;
      ERR:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath; cpu_hold and words_loaded update on the transition into OK so
  // they are already valid while load_done pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len          <= '0;
      chk          <= '0;
      wr_cnt       <= '0;
      word         <= '0;
      byte_idx     <= '0;
      cpu_hold     <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: if (rx_fire && rx_data == SYNC) begin
          chk      <= '0;
          wr_cnt   <= '0;
          cpu_hold <= 1'b1;
        end
        LEN_HI: if (rx_fire) begin
          len[15:8] <= rx_data;
          chk       <= chk_in;
        end
        LEN_LO: if (rx_fire) begin
          len      <= len_in;
          chk      <= chk_in;
          byte_idx <= '0;
        end
        DATA: if (rx_fire) begin
          word     <= {word[23:0], rx_data};
          chk      <= chk_in;
          byte_idx <= byte_idx + 1'b1;
        end
        WRITE: wr_cnt <= wr_nxt;
        CSUM: if (rx_fire) begin
          chk <= chk_in;
          if (chk_in == 8'd0) begin
            words_loaded <= len[ADDR_W:0];
            cpu_hold     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level reference model queues the
// expected RAM writes and accept/reject pulses, a monitor compares them.
`timescale 1ns/1ps
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W  = 11;
  localparam int TIMEOUT = 300;
  localparam int MAX_LEN = 2 ** ADDR_W;
  localparam int BUDGET  = TIMEOUT + 100;
  localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .SYNC(SYNC_BYTE)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   hold_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic void push_exp(input int k, input int a, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  // Reference: interpret a whole byte stream as one frame; a stream that ends
  // early is an idle line, which must end in a reject.
  task automatic model(input bq_t s);
    int i = 0;
    int len;
    logic [7:0] sum;
    while (i < s.size() && s[i] != SYNC_BYTE) i++;
    if (i >= s.size()) return;
    hold_exp = 1'b1;
    i++;
    if (i + 2 > s.size()) begin push_exp(K_ERR, 0, 0); return; end
    len = int'({s[i], s[i+1]});
    sum = s[i] + s[i+1];
    i += 2;
    if (len > MAX_LEN) begin push_exp(K_ERR, 0, 0); return; end
    for (int k = 0; k < len; k++) begin
      if (i + 4 > s.size()) begin push_exp(K_ERR, 0, 0); return; end
      push_exp(K_WR, k, {s[i], s[i+1], s[i+2], s[i+3]});
      sum = sum + s[i] + s[i+1] + s[i+2] + s[i+3];
      i += 4;
    end
    if (i >= s.size()) begin push_exp(K_ERR, 0, 0); return; end
    sum = sum + s[i];
    if (sum == 8'd0) begin
      push_exp(K_DONE, 0, 32'(len));
      hold_exp = 1'b0;
    end else begin
      push_exp(K_ERR, 0, 0);
    end
  endtask

  task automatic make_frame(input int len, input bit good, input int garbage, output bq_t s);
    logic [7:0] sum, b;
    s = {};
    repeat (garbage) begin
      b = 8'($urandom);
      if (b == SYNC_BYTE) b = 8'h00;
      s.push_back(b);
    end
    s.push_back(SYNC_BYTE);
    s.push_back(8'(len >> 8));
    s.push_back(8'(len));
    if (len > MAX_LEN) return;
    sum = 8'(len >> 8) + 8'(len);
    for (int k = 0; k < 4 * len; k++) begin
      b = 8'($urandom);
      s.push_back(b);
      sum = sum + b;
    end
    b = 8'd0 - sum;
    if (!good) b = b + 8'($urandom_range(1, 255));
    s.push_back(b);
  endtask

  // Called at a negedge; returns at a negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit cont);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) check("rx_ready_stuck_low", rx_ready, 1);
    @(negedge CLK);
    if (!cont) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic send_stream(input bq_t s, input bit cont);
    foreach (s[k]) send_byte(s[k], cont);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge CLK); n++; end
    check("pending_outputs", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_frame(input bq_t s, input bit cont);
    model(s);
    send_stream(s, cont);
    wait_drain(BUDGET);
    repeat (3) @(negedge CLK);
    check("cpu_hold_after_frame", cpu_hold, hold_exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_error"}, load_error, 0);
    check({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (ram_we || load_done || load_error) begin
        check("rx_ready_low_on_event", rx_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", {ram_we, load_done, load_error}, 0);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_kind = ram_we ? K_WR : (load_done ? K_DONE : K_ERR);
          check("output_kind", mon_kind, mon_e.kind);
          if (ram_we) begin
            check("ram_addr", ram_addr, mon_e.addr);
            check("ram_wdata", ram_wdata, mon_e.data);
          end else if (load_done) begin
            check("words_loaded", words_loaded, mon_e.data);
            check("cpu_hold_on_done", cpu_hold, 0);
          end else begin
            check("cpu_hold_on_error", cpu_hold, 1);
          end
        end
      end else if (!rx_ready) begin
        check("rx_ready_low_outside_write", rx_ready, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    int  len;
    repeat (3) @(negedge CLK);
    check_reset_values("por");
    RST = 1'b0;
    @(negedge CLK);

    run_frame({8'hA5, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h01, 8'hDE}, 1'b0);
    run_frame({8'hA5, 8'h00, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00,
               8'h30, 8'h00, 8'h00, 8'h00, 8'hBD}, 1'b0);
    run_frame({8'hA5, 8'h00, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00,
               8'h30, 8'h00, 8'h00, 8'h00, 8'hBC}, 1'b0);
    run_frame({8'h00, 8'hFF, 8'h13}, 1'b0);
    run_frame({8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
    run_frame({8'hA5, 8'h08, 8'h01}, 1'b0);
    run_frame({8'hA5, 8'h00, 8'h01, 8'h20}, 1'b0);
    // SYNC inside data is ordinary payload
    run_frame({8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'hB4}, 1'b1);
    run_frame({8'hA5, 8'h00, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00,
               8'h30, 8'h00, 8'h00, 8'h00, 8'hBD}, 1'b1);

    make_frame(MAX_LEN, 1'b1, 0, s);
    run_frame(s, 1'b1);
    make_frame(MAX_LEN + 1, 1'b1, 0, s);
    run_frame(s, 1'b0);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(MAX_LEN + 1, 65535);
      else                           len = $urandom_range(0, 6);
      make_frame(len, $urandom_range(0, 3) != 0, $urandom_range(0, 3), s);
      if ($urandom_range(0, 7) == 0)
        repeat ($urandom_range(1, 3)) if (s.size() > 1) void'(s.pop_back());
      run_frame(s, $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of a 3-word frame, one word already written
    make_frame(3, 1'b1, 0, s);
    push_exp(K_WR, 0, {s[3], s[4], s[5], s[6]});
    for (int k = 0; k < 8; k++) send_byte(s[k], 1'b0);
    rx_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_frame_write", exp_q.size(), 0);
    exp_q.delete();
    #2 RST = 1'b1;
    #1 check_reset_values("async_rst");
    hold_exp = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    make_frame(3, 1'b1, 0, s);
    run_frame(s, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction RAM that the core fetches from.
- Receives a framed byte stream (valid/ready, e.g. from a UART receiver) and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive RAM addresses from 0, holding the core while loading.
- Reports success or failure per frame with one-cycle pulses.

Parameters:
- ADDR_W, 11, RAM word-address width (2**ADDR_W words).
- TIMEOUT, 160000, max idle cycles between bytes inside a frame (10 ms at 16 MHz).
- SYNC, 8'hA5, frame start byte.

Ports:
- CLK  in  1  system clock, 16 MHz.
- RST  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready.
- ram_we  out  1  RAM write strobe, one cycle per word.
- ram_addr  out  ADDR_W  write address.
- ram_wdata  out  32  write data.
- cpu_hold  out  1  core must stall and restart at pc 0 on release.
- load_done  out  1  one-cycle pulse, frame accepted.
- load_error  out  1  one-cycle pulse, frame rejected.
- words_loaded  out  ADDR_W+1  word count of last frame (valid after load_done).

Behaviour:
- Reset is asynchronous and active-high on RST; CLK is the single clock.
- Reset values: state IDLE; rx_ready=1; ram_we=0; ram_addr=0; ram_wdata=0; cpu_hold=0; load_done=0; load_error=0; words_loaded=0; checksum=0; timer=0.
- Frame format: SYNC, LEN_HI, LEN_LO, LEN×4 data bytes (MSB first), CSUM.
- Frame is valid when (LEN_HI + LEN_LO + all data bytes + CSUM) mod 256 == 0.
- States:
  - IDLE: non-SYNC bytes are discarded. On SYNC: clear checksum and address, set cpu_hold=1, go to LEN_HI.
  - LEN_HI: latch the byte and add it to the checksum; go to LEN_LO.
  - LEN_LO: form LEN. If LEN > 2**ADDR_W, go to ERR. If LEN == 0, go to CSUM. Otherwise go to DATA, byte index 0.
  - DATA: shift each byte into the word register and add it to the checksum. On byte index 3, go to WRITE.
  - WRITE: lasts exactly one cycle. ram_we=1, ram_addr=current address, ram_wdata=assembled word, rx_ready=0. Then increment the address. If the words written equal LEN, go to CSUM; otherwise go to DATA.
  - CSUM: add the byte. If the total is 0, go to OK; otherwise go to ERR.
  - OK: one cycle. load_done=1, words_loaded=LEN, cpu_hold=0, then go to IDLE.
  - ERR: one cycle. load_error=1, cpu_hold stays 1 (RAM contents untrusted), then go to IDLE.
- Latency: the 4th data byte accepted in cycle N gives ram_we in cycle N+1. The final CSUM byte in cycle M gives load_done/load_error in cycle M+1.
- rx_ready is 1 in every state except WRITE, OK and ERR.
- Timeout: the timer clears on every accepted byte and in IDLE. In any other state, when the timer reaches TIMEOUT, go to ERR (partial writes remain).
- A SYNC byte inside a frame is treated as ordinary data; there is no resync mid-frame.
- cpu_hold after an error is released only by a later successful frame or by RST.
- RST mid-frame aborts immediately: no further writes and cpu_hold=0.
- Address wrap cannot occur: the LEN check bounds the address to 2**ADDR_W−1.
- All checksum arithmetic is 8-bit modulo; LEN is 16-bit unsigned.

Decomposition:
- Shared package prog_loader_pkg:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, OK, ERR);
  - SYNC_BYTE constant;
  - instruction opcode constants shared with the core (LED 32'h2000000x, SLEEP 32'h1xxxxxxx, JUMP0 32'h30000000) for test programs.
- One sub-module, loader_timer: clear/enable inputs, expired output, width sized from TIMEOUT.

Test Plan:
- Send A5 00 01 20 00 00 01 DE → one ram_we, addr 0, data 32'h20000001; load_done pulse; words_loaded=1; cpu_hold falls.
- Send A5 00 02 11 00 00 00 30 00 00 00 BD → writes addr0=32'h11000000, addr1=32'h30000000, then load_done. Repeat with CSUM BC → both writes occur, then load_error, cpu_hold stays 1.
- Send bytes 00 FF 13 then A5 00 00 00 → leading bytes ignored, no writes, load_done, words_loaded=0.
- Send A5 08 01 → load_error after LEN_LO, no ram_we.
- Send A5 00 01 20, then stall rx_valid for TIMEOUT cycles → load_error with no write. Also hold rx_valid=1 continuously: rx_ready drops exactly in each WRITE cycle and no byte is lost.
- Assert RST during DATA of a 3-word frame → outputs return to reset values asynchronously; the next full frame loads correctly from addr 0.
